// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;
  localparam int   PS2_DATA_BITS = 8;

  // Scan codes that show up often on the wire
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO holding received bytes; head is shown combinationally.
module ps2_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the simultaneous push needs
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are only visible while occupancy says so
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin conditioning, frame deframer, error flags
// and a byte FIFO whose head is the bus interface's read register.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clr,
  input  logic       err_clr,
  output logic [7:0] rd_data,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]     ps2_clk_sync_q, ps2_data_sync_q;
  logic           filt_q, filt_prev_q;
  logic [FCW-1:0] fcnt_q;
  logic           fall;
  logic           data_s;

  ps2_state_e     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           push_q, push_d;
  logic [7:0]     push_data_q;
  logic           frame_evt, par_evt, ovf_evt;

  logic           clr_d_q;
  logic           pop;
  logic           fifo_empty;
  logic           parity_err_q, frame_err_q, overflow_q;

  assign data_s = ps2_data_sync_q[1];
  assign fall   = filt_prev_q & ~filt_q;
  assign pop    = clr & ~clr_d_q;

  // Two-flop synchronisers; idle PS/2 lines float high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_clk_sync_q  <= 2'b11;
      ps2_data_sync_q <= 2'b11;
    end else begin
      ps2_clk_sync_q  <= {ps2_clk_sync_q[0], ps2_clk};
      ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data};
    end
  end

  // Clock filter: follow the synchronised clock only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (ps2_clk_sync_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q <= ps2_clk_sync_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FCW'(1);
      end
    end
  end

  // Deframer next-state logic, including the mid-frame watchdog
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    push_d    = 1'b0;
    frame_evt = 1'b0;
    par_evt   = 1'b0;

    if (state_q == IDLE || fall) tmo_d = '0;
    else                         tmo_d = tmo_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (fall && data_s == PS2_START_BIT) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
          else                                    bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (data_s != PS2_STOP_BIT)              frame_evt = 1'b1;
          else if (!ps2_parity_ok(shift_q, par_q)) par_evt   = 1'b1;
          else                                     push_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled device clock abandons the partial byte
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC)) begin
      state_d   = IDLE;
      frame_evt = 1'b1;
      push_d    = 1'b0;
    end
  end

  // Deframer state, timeout counter and push strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      push_q    <= push_d;
    end
  end

  // Shift register and the byte handed to the FIFO (data only, no reset needed)
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push_d) push_data_q <= shift_q;
  end

  // A good byte arriving at a full FIFO with no pop in the same cycle is lost
  assign ovf_evt = push_q & fifo_full & ~pop;

  // clr edge detector and sticky error flags; a new event beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_d_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      clr_d_q      <= clr;
      parity_err_q <= par_evt   | (parity_err_q & ~err_clr);
      frame_err_q  <= frame_evt | (frame_err_q  & ~err_clr);
      overflow_q   <= ovf_evt   | (overflow_q   & ~err_clr);
    end
  end

  ps2_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(PS2_DATA_BITS)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push_q),
    .pop_i  (pop),
    .wdata_i(push_data_q),
    .head_o (rd_data),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign data_valid = ~fifo_empty;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
